// File: rtl/bus3_rr_arbiter_if.sv
// Bundle between the three requesters / consumer and the round-robin arbiter.
// The master side drives the sources and the consumer ready; the slave side is the arbiter.
interface bus3_rr_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
);
  logic [2:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [2:0]       ack;
  logic [1:0]       sel;
  logic [2:0]       grant;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;
  logic [CNTW-1:0]  cnt2;

  modport master (
    output req, data0, data1, data2, out_ready,
    input  ack, sel, grant, out_valid, out_data, cnt0, cnt1, cnt2
  );

  modport slave (
    input  req, data0, data1, data2, out_ready,
    output ack, sel, grant, out_valid, out_data, cnt0, cnt1, cnt2
  );
endinterface

// File: rtl/bus3_rr_arbiter.sv
// 3-way round-robin arbiter feeding a single output staging register,
// with per-requester saturating accepted-word counters.
module bus3_rr_cnt #(
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

module bus3_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bus3_rr_arbiter_if.slave   bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t                     state, state_nx;
  logic [1:0]                 last, win;
  logic                       any, can_load, capture;
  logic [WIDTH-1:0]           mux_data, out_data;
  logic [2:0]                 grant, ack;
  logic [2:0][CNTW-1:0]       cnt;

  assign any      = |bus.req;
  assign can_load = (state == EMPTY) || bus.out_ready;
  assign capture  = can_load && any;

  // Search starts one past the previous winner; last=3 never occurs but behaves like 2.
  always_comb begin
    win = 2'd0;
    unique case (last)
      2'd0: begin
        if      (bus.req[1]) win = 2'd1;
        else if (bus.req[2]) win = 2'd2;
        else                 win = 2'd0;
      end
      2'd1: begin
        if      (bus.req[2]) win = 2'd2;
        else if (bus.req[0]) win = 2'd0;
        else if (bus.req[1]) win = 2'd1;
      end
      default: begin
        if      (bus.req[0]) win = 2'd0;
        else if (bus.req[1]) win = 2'd1;
        else if (bus.req[2]) win = 2'd2;
      end
    endcase
  end

  always_comb begin
    mux_data = bus.data0;
    case (win)
      2'd1:    mux_data = bus.data1;
      2'd2:    mux_data = bus.data2;
      default: mux_data = bus.data0;
    endcase
  end

  assign ack = capture ? (3'b001 << win) : 3'b000;

  always_comb begin
    state_nx = state;
    if (capture)                          state_nx = FULL;
    else if (state == FULL && bus.out_ready) state_nx = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      grant    <= 3'b000;
      last     <= 2'd2;
    end else begin
      state <= state_nx;
      if (capture) begin
        out_data <= mux_data;
        grant    <= 3'b001 << win;
        last     <= win;
      end else if (state == FULL && bus.out_ready) begin
        grant <= 3'b000;
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    bus3_rr_cnt #(.CNTW(CNTW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ack[i]),
      .cnt   (cnt[i])
    );
  end

  assign bus.ack       = ack;
  assign bus.sel       = win;
  assign bus.grant     = grant;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data;
  assign bus.cnt0      = cnt[0];
  assign bus.cnt1      = cnt[1];
  assign bus.cnt2      = cnt[2];
endmodule

// File: tb/tb_bus3_rr_arbiter.sv
// Directed bench for bus3_rr_arbiter: reset, fairness, backpressure, skip, drain, saturation.
module tb_bus3_rr_arbiter;
  localparam int WIDTH = 32;
  localparam int CNTW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bus3_rr_arbiter_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  bus3_rr_arbiter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [WIDTH-1:0] D0 = 32'h0000_AAAA;
  localparam logic [WIDTH-1:0] D1 = 32'h0000_5555;
  localparam logic [WIDTH-1:0] D2 = 32'h0000_7777;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = 3'b111; bus.out_ready = 1'b1;
    bus.data0 = D0; bus.data1 = D1; bus.data2 = D2;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
    checks++; if (bus.grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", bus.grant); end
    checks++; if ({bus.cnt0, bus.cnt1, bus.cnt2} !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%h/%h/%h exp=0/0/0", bus.cnt0, bus.cnt1, bus.cnt2); end
    tick(); tick();
    #2 rst_n = 1'b1;
    #1;
    checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL reset_first_ack got=%b exp=001", bus.ack); end
    checks++; if (bus.sel !== 2'b00) begin failures++; $display("FAIL reset_first_sel got=%b exp=00", bus.sel); end
  endtask

  task automatic test_fairness();
    logic [WIDTH-1:0] exp_d [3];
    logic [2:0] exp_a;
    exp_d[0] = D0; exp_d[1] = D1; exp_d[2] = D2;
    for (int i = 0; i < 6; i++) begin
      exp_a = 3'b001 << (i % 3);
      checks++; if (bus.ack !== exp_a) begin failures++; $display("FAIL fair_ack[%0d] got=%b exp=%b", i, bus.ack, exp_a); end
      checks++; if (bus.sel !== 2'(i % 3)) begin failures++; $display("FAIL fair_sel[%0d] got=%b exp=%0d", i, bus.sel, i % 3); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[i % 3] || bus.grant !== exp_a) begin
        failures++; $display("FAIL fair_out[%0d] got=%b/%h/%b exp=1/%h/%b", i, bus.out_valid, bus.out_data, bus.grant, exp_d[i % 3], exp_a);
      end
    end
    checks++; if ({bus.cnt0, bus.cnt1, bus.cnt2} !== {2'd2, 2'd2, 2'd2}) begin failures++; $display("FAIL fair_cnt got=%0d/%0d/%0d exp=2/2/2", bus.cnt0, bus.cnt1, bus.cnt2); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0; bus.req = 3'b010;
    #1;
    checks++; if (bus.ack !== 3'b000) begin failures++; $display("FAIL bp_ack0 got=%b exp=000", bus.ack); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.ack !== 3'b000 || bus.out_data !== D2 || bus.grant !== 3'b100 || bus.out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%b/%b exp=000/%h/100/1", i, bus.ack, bus.out_data, bus.grant, bus.out_valid, D2);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.ack !== 3'b010 || bus.sel !== 2'b01) begin failures++; $display("FAIL bp_release got=%b/%b exp=010/01", bus.ack, bus.sel); end
    tick();
    checks++; if (bus.out_data !== D1 || bus.grant !== 3'b010) begin failures++; $display("FAIL bp_new got=%h/%b exp=%h/010", bus.out_data, bus.grant, D1); end
    checks++; if (bus.cnt1 !== 2'd3) begin failures++; $display("FAIL bp_cnt1 got=%0d exp=3", bus.cnt1); end
  endtask

  task automatic test_skip_idle();
    bus.req = 3'b001;
    #1;
    checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL skip_pre got=%b exp=001", bus.ack); end
    tick();
    bus.req = 3'b100;
    #1;
    checks++; if (bus.ack !== 3'b100 || bus.sel !== 2'b10) begin failures++; $display("FAIL skip_r2 got=%b/%b exp=100/10", bus.ack, bus.sel); end
    tick();
    checks++; if (bus.out_data !== D2 || bus.grant !== 3'b100) begin failures++; $display("FAIL skip_r2_out got=%h/%b exp=%h/100", bus.out_data, bus.grant, D2); end
    bus.req = 3'b001;
    #1;
    checks++; if (bus.ack !== 3'b001 || bus.sel !== 2'b00) begin failures++; $display("FAIL skip_r0 got=%b/%b exp=001/00", bus.ack, bus.sel); end
    tick();
    checks++; if (bus.cnt0 !== 2'd3 || bus.cnt2 !== 2'd3) begin failures++; $display("FAIL skip_cnt got=%0d/%0d exp=3/3", bus.cnt0, bus.cnt2); end
  endtask

  task automatic test_drain();
    bus.req = 3'b000;
    #1;
    checks++; if (bus.ack !== 3'b000 || bus.sel !== 2'b00) begin failures++; $display("FAIL drain_comb got=%b/%b exp=000/00", bus.ack, bus.sel); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.grant !== 3'b000 || bus.out_data !== D0) begin
      failures++; $display("FAIL drain_out got=%b/%b/%h exp=0/000/%h", bus.out_valid, bus.grant, bus.out_data, D0);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== D0) begin failures++; $display("FAIL drain_hold got=%b/%h exp=0/%h", bus.out_valid, bus.out_data, D0); end
  endtask

  task automatic test_saturation_reset();
    logic [CNTW-1:0] exp_c;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    bus.req = 3'b010;
    for (int k = 1; k <= 5; k++) begin
      #1;
      checks++; if (bus.ack !== 3'b010) begin failures++; $display("FAIL sat_ack[%0d] got=%b exp=010", k, bus.ack); end
      tick();
      exp_c = (k > 3) ? 2'd3 : 2'(k);
      checks++; if (bus.cnt1 !== exp_c) begin failures++; $display("FAIL sat_cnt1[%0d] got=%0d exp=%0d", k, bus.cnt1, exp_c); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.grant !== 3'b000 || bus.cnt1 !== 2'd0) begin
      failures++; $display("FAIL midrst got=%b/%h/%b/%0d exp=0/0/000/0", bus.out_valid, bus.out_data, bus.grant, bus.cnt1);
    end
    bus.req = 3'b000;
    #1;
    checks++; if (bus.ack !== 3'b000 || bus.sel !== 2'b00) begin failures++; $display("FAIL midrst_comb got=%b/%b exp=000/00", bus.ack, bus.sel); end
    #3 rst_n = 1'b1;
    bus.req = 3'b111;
    #1;
    checks++; if (bus.ack !== 3'b001) begin failures++; $display("FAIL midrst_prio got=%b exp=001", bus.ack); end
  endtask

  initial begin
    bus.req = 3'b000; bus.out_ready = 1'b0;
    bus.data0 = '0; bus.data1 = '0; bus.data2 = '0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_skip_idle();
    test_drain();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus3_rr_arbiter.md
# bus3_rr_arbiter

Round-robin arbiter and output staging register for a shared 32-bit datapath fed by three requesters. Each cycle it picks at most one requesting source and drives the 2-bit select of the team's 32-bit 3:1 mux. It captures the selected word into an output register with a valid/ready handshake toward the consumer. It also counts accepted words per requester for debug.

## Interface
Parameters:
- `WIDTH`, 32: data width of every source and of the output.
- `CNTW`, 8: width of each per-requester accepted-word counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  3  `req[i]`=1: requester i has a valid word on `data_i`.
- `data0`, `data1`, `data2`  in  WIDTH each  source words.
- `ack`  out  3  one-hot or zero; `ack[i]`=1 means `data_i` is captured at this clock edge.
- `sel`  out  2  mux select: 00 selects data0, 01 selects data1, 10 selects data2; 11 is never driven.
- `grant`  out  3  one-hot registered owner of the word currently in the output register; 0 when the register is empty.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered word.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.
- `cnt0`, `cnt1`, `cnt2`  out  CNTW each  saturating count of accepted words per requester.

## Operation
- State is held in the output register: EMPTY (`out_valid`=0) or FULL (`out_valid`=1).
- `can_load` = `!out_valid || out_ready`.
- `capture` = `can_load && |req`.
- Winner selection is round-robin. Search order starts at `(last+1) mod 3` and wraps; the first set `req` bit wins. `last` is a 2-bit register holding the previous winner.
- `sel` is the combinational encoding of the winner whenever `|req`, regardless of `can_load`. When `req`==0, `sel`=00.
- `ack[winner]` = `capture`. It is combinational from `req`, `out_valid`, `out_ready`, and `last`.
- A requester holds `req` and data stable until acked. After an ack it may drop `req` or present the next word.
- On a `capture` edge:
  - `out_data` <= muxed word.
  - `out_valid` <= 1.
  - `grant` <= one-hot winner.
  - `last` <= winner.
  - `cnt_winner` increments, saturating at all-ones.
- On an edge with `out_valid && out_ready && !capture`: `out_valid` <= 0 and `grant` <= 0. `out_data` holds its last value.
- With `out_valid && !out_ready`: everything holds and no ack is issued.
- `last` updates only on capture. Non-requesting sources are skipped with no wasted cycle.

## Timing
- Reset (async assert, any cycle including mid-transfer) forces:
  - `out_valid`=0, `out_data`=0, `grant`=0
  - `last`=2, so requester 0 has first priority
  - `cnt0`..`cnt2`=0
  - `ack`=0 and `sel`=00 while `req`=0
- A word in flight is discarded on reset.
- Latency: ack in cycle N, then `out_valid`=1 with that word in cycle N+1.
- Throughput: one word per cycle when `out_ready` is held at 1. Drain and refill happen in the same edge (FULL→FULL with a new word).
- A requester held continuously is served at least once every 3 captures.
- No combinational path exists from `out_data` to the sources. `ack` depends combinationally on `out_ready`.

## Test plan
- Reset check: assert `rst_n`=0 with `req`=111 -> `out_valid`=0, `out_data`=0, `grant`=0, counters 0. After release, the first ack goes to requester 0, with `sel`=00.
- Fairness: `req`=111 held, `out_ready`=1, data0/1/2 = 0xAAAA/0x5555/0x7777 -> acks 001,010,100,001,… and `out_data` sequence 0xAAAA,0x5555,0x7777,… one per cycle.
- Backpressure: fill the register, hold `out_ready`=0 for 5 cycles with `req`=010 -> `ack`=0, `out_data` and `grant` stable. The cycle `out_ready` rises, `ack`=010 and the new word appears the next cycle.
- Skip idle sources: `last`=0 and `req`=100 -> immediate `ack`=100, `sel`=10. Then `req`=001 -> `ack`=001, `sel`=00.
- Drain to empty: one word accepted with `req`=0 -> `out_valid` falls, `grant`=0, `out_data` holds its value.
- Saturation and mid-run reset: `CNTW`=2, requester 1 alone for 5 captures -> `cnt1`=3. Pulse `rst_n` low mid-burst -> all outputs return to reset values asynchronously.
